// File: rtl/q15_pkg.sv
// Shared definitions for the Q15.48 fixed-point datapath.
// Contents:
//   Q15_WIDTH / Q15_FRAC : operand width and fraction bit count
//   Q15_MAX / Q15_MIN_SAT: symmetric saturation limits (the most negative code
//                          is never produced, so +/- saturation are mirror images)
//   Q15_ONE              : the value 1.0
//   state_t              : divider FSM state encoding
//   q15_abs()            : two's-complement magnitude; the most negative input
//                          maps to 2^63, which is representable as unsigned
package q15_pkg;

    localparam int          Q15_WIDTH   = 64;
    localparam int          Q15_FRAC    = 48;
    localparam logic [63:0] Q15_MAX     = 64'h7fff_ffff_ffff_ffff;
    localparam logic [63:0] Q15_MIN_SAT = 64'h8000_0000_0000_0001;
    localparam logic [63:0] Q15_ONE     = 64'h0001_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DIV,
        DONE
    } state_t;

    function automatic logic [63:0] q15_abs(input logic [63:0] v);
        return v[63] ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/q15_div_seq_if.sv
// Operand/result bundle of the Q15.48 divider.
// Signals:
//   in_valid/in_ready, num, den   : operand channel (master -> slave)
//   out_valid/out_ready, quot,
//   ovf, dbz                      : result channel (slave -> master)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The operand payload only has to be stable in that cycle.
// The result payload (quot/ovf/dbz) stays stable while out_valid is high and
// out_ready is low; valid never drops before the transfer completes.
interface q15_div_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quot;
    logic             ovf;
    logic             dbz;

    modport master (
        output in_valid, num, den, out_ready,
        input  in_ready, out_valid, quot, ovf, dbz
    );

    modport slave (
        input  in_valid, num, den, out_ready,
        output in_ready, out_valid, quot, ovf, dbz
    );
endinterface

// File: rtl/q15_div_step.sv
// One restoring-division iteration: shift the partial remainder left, bring in
// the next dividend bit, subtract the divisor when it fits.
// Ports:
//   rem      in  WIDTH    partial remainder (always < den)
//   den      in  WIDTH    divisor magnitude (non-zero)
//   bit_in   in  1        next dividend bit, MSB first
//   rem_next out WIDTH    updated remainder
//   q_bit    out 1        quotient bit for this iteration
module q15_div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] den,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    // rem < den <= 2^63, so the shifted value needs one extra bit but the
    // result after a conditional subtract fits back into WIDTH bits.
    logic [WIDTH:0] shifted;

    always_comb begin
        shifted  = {rem, bit_in};
        q_bit    = (shifted >= {1'b0, den});
        rem_next = q_bit ? (shifted[WIDTH-1:0] - den) : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/q15_div_seq.sv
// Iterative restoring divider for signed Q15.48 operands.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : q15_div_seq_if slave (operands in, quotient/ovf/dbz out)
//   dbg_state  : current FSM state
// Optional build macro Q15_DIV_ROUND_EN: one extra guard iteration and
// round-half-up of the magnitude; default build truncates toward zero.
module q15_div_seq
    import q15_pkg::*;
#(
    parameter int FRAC_BITS = Q15_FRAC,
    parameter int WIDTH     = Q15_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    q15_div_seq_if.slave  bus,
    output state_t        dbg_state
);
    localparam int DW    = WIDTH + FRAC_BITS;       // pre-scaled dividend width
    localparam int IBITS = WIDTH - FRAC_BITS - 1;   // integer bits excluding sign
`ifdef Q15_DIV_ROUND_EN
    localparam int QW = WIDTH + 1;                  // quotient plus guard bit
`else
    localparam int QW = WIDTH;
`endif
    localparam logic [6:0] CNT_START = 7'(QW - 1);

    state_t           state, state_next;
    logic             sign;
    logic [WIDTH-1:0] mag_n, mag_d;
    logic [DW-1:0]    div_sr;
    logic [WIDTH-1:0] rem, rem_next;
    logic [QW-1:0]    q_acc, q_full;
    logic [6:0]       cnt;
    logic             q_bit;
    logic [WIDTH-1:0] quot_r;
    logic             ovf_r, dbz_r;
    logic             too_big;
    logic [WIDTH-1:0] mag_final;
    logic             round_sat;

    q15_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .den      (mag_d),
        .bit_in   (div_sr[DW-1]),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Quotient magnitude reaches 2^63 exactly when mag_n >= mag_d * 2^IBITS.
    assign too_big = {{(IBITS+1){1'b0}}, mag_n} >= {1'b0, mag_d, {IBITS{1'b0}}};

    always_comb begin
        q_full    = QW'({q_acc, q_bit});
        round_sat = 1'b0;
`ifdef Q15_DIV_ROUND_EN
        begin
            logic [QW-1:0] rounded;
            rounded   = {1'b0, q_full[QW-1:1]} + QW'(q_full[0]);
            round_sat = (rounded[QW-1:WIDTH-1] != '0);
            mag_final = rounded[WIDTH-1:0];
        end
`else
        mag_final = q_full;
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)                  state_next = CHECK;
            CHECK:   if (mag_d == '0 || too_big)        state_next = DONE;
                     else                               state_next = DIV;
            DIV:     if (cnt == 7'd0)                   state_next = DONE;
            DONE:    if (bus.out_ready)                 state_next = IDLE;
            default:                                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            quot_r <= '0;
            ovf_r  <= 1'b0;
            dbz_r  <= 1'b0;
            sign   <= 1'b0;
            mag_n  <= '0;
            mag_d  <= '0;
            div_sr <= '0;
            rem    <= '0;
            q_acc  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (bus.in_valid) begin
                    sign   <= bus.num[WIDTH-1] ^ bus.den[WIDTH-1];
                    mag_n  <= q15_abs(bus.num);
                    mag_d  <= q15_abs(bus.den);
                    div_sr <= {q15_abs(bus.num), {FRAC_BITS{1'b0}}};
                    ovf_r  <= 1'b0;
                    dbz_r  <= 1'b0;
                end
                CHECK: begin
                    if (mag_d == '0) begin
                        // den is +0 here, so sign equals the sign of num.
                        dbz_r  <= 1'b1;
                        quot_r <= (mag_n == '0) ? '0 : (sign ? Q15_MIN_SAT : Q15_MAX);
                    end else if (too_big) begin
                        ovf_r  <= 1'b1;
                        quot_r <= sign ? Q15_MIN_SAT : Q15_MAX;
                    end else begin
                        // Upper dividend bits are below mag_d (no overflow), so
                        // they seed the remainder and only the low WIDTH bits
                        // need iterating.
                        rem    <= {{(2*WIDTH-DW){1'b0}}, div_sr[DW-1:WIDTH]};
                        div_sr <= div_sr << (DW - WIDTH);
                        q_acc  <= '0;
                        cnt    <= CNT_START;
                    end
                end
                DIV: begin
                    rem    <= rem_next;
                    div_sr <= div_sr << 1;
                    q_acc  <= q_full;
                    cnt    <= cnt - 7'd1;
                    if (cnt == 7'd0) begin
                        if (round_sat) begin
                            ovf_r  <= 1'b1;
                            quot_r <= sign ? Q15_MIN_SAT : Q15_MAX;
                        end else begin
                            quot_r <= sign ? (~mag_final + 1'b1) : mag_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quot      = quot_r;
    assign bus.ovf       = ovf_r;
    assign bus.dbz       = dbz_r;
    assign dbg_state     = state;

endmodule

// File: tb/tb_q15_div_seq.sv
// Bench for q15_div_seq: directed vector table, hand-written backpressure and
// mid-division reset sequences, then randomized operands checked against an
// arithmetic reference model. Honors Q15_DIV_ROUND_EN.
module tb_q15_div_seq;
    import q15_pkg::*;

`ifdef Q15_DIV_ROUND_EN
    localparam int NORM_LAT = 67;
`else
    localparam int NORM_LAT = 66;
`endif
    localparam int SAT_LAT = 2;

    typedef struct {
        logic [63:0] num;
        logic [63:0] den;
        logic [63:0] quot;
        logic        ovf;
        logic        dbz;
        int          lat;
    } vec_t;

    logic   clk = 1'b0;
    logic   reset;
    state_t dbg_state;
    int     tests  = 0;
    int     failed = 0;
    logic [65:0] exp_q[$];

    q15_div_seq_if bus ();

    q15_div_seq dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] abs64(input logic [63:0] v);
        return v[63] ? (64'd0 - v) : v;
    endfunction

    function automatic void model(input logic [63:0] n, input logic [63:0] d,
                                  output logic [63:0] q, output logic o, output logic z);
        logic [127:0] an, ad, qq;
        logic         neg;
        an  = {64'd0, abs64(n)};
        ad  = {64'd0, abs64(d)};
        neg = n[63] ^ d[63];
        o   = 1'b0;
        z   = 1'b0;
        if (ad == 128'd0) begin
            z = 1'b1;
            q = (an == 128'd0) ? 64'd0 : (n[63] ? Q15_MIN_SAT : Q15_MAX);
        end else begin
`ifdef Q15_DIV_ROUND_EN
            qq = (((an << 49) / ad) + 128'd1) >> 1;
`else
            qq = (an << 48) / ad;
`endif
            if (qq >= (128'd1 << 63)) begin
                o = 1'b1;
                q = neg ? Q15_MIN_SAT : Q15_MAX;
            end else begin
                q = neg ? (64'd0 - qq[63:0]) : qq[63:0];
            end
        end
    endfunction

    // ---------------- driver ----------------
    // Presents operands, waits for acceptance, then counts cycles until
    // out_valid (cycle 1 is the first cycle after the accepting edge).
    task automatic run_div(input logic [63:0] n, input logic [63:0] d, input logic rdy,
                           output logic [63:0] q, output logic o, output logic z,
                           output int lat);
        int w;
        @(negedge clk);
        bus.num       = n;
        bus.den       = d;
        bus.in_valid  = 1'b1;
        bus.out_ready = rdy;
        w = 0;
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            tests++;
            failed++;
            $display("FAIL accept_timeout: in_ready stuck low");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.num      = {$urandom, $urandom};
        bus.den      = {$urandom, $urandom};
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 300);
        if (!bus.out_valid) begin
            tests++;
            failed++;
            $display("FAIL result_timeout: out_valid not seen after %0d cycles", lat);
        end
        q = bus.quot;
        o = bus.ovf;
        z = bus.dbz;
    endtask

    // With out_ready high, exactly one DONE cycle, then back to IDLE.
    task automatic check_release(input string name);
        @(negedge clk);
        check({name, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
        check({name, "_ready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    vec_t        vecs[12];
    logic [63:0] q, hold_q, rn, rd, eq;
    logic        o, z, eo, ez;
    logic [65:0] exp_item;
    int          lat;

    initial begin
        bus.in_valid  = 1'b0;
        bus.num       = '0;
        bus.den       = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_state",     64'(dbg_state),     64'(IDLE));
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_quot",      bus.quot,           64'd0);
        check("rst_ovf",       64'(bus.ovf),       64'd0);
        check("rst_dbz",       64'(bus.dbz),       64'd0);

        // Directed vectors
        vecs[0]  = '{64'h0001_0000_0000_0000, 64'h0002_0000_0000_0000, 64'h0000_8000_0000_0000, 1'b0, 1'b0, NORM_LAT};
        vecs[1]  = '{64'hfffd_0000_0000_0000, 64'h0001_8000_0000_0000, 64'hfffe_0000_0000_0000, 1'b0, 1'b0, NORM_LAT};
        vecs[2]  = '{64'h4000_0000_0000_0000, 64'h0000_0100_0000_0000, Q15_MAX,                1'b1, 1'b0, SAT_LAT};
        vecs[3]  = '{64'h4000_0000_0000_0000, 64'hffff_ff00_0000_0000, Q15_MIN_SAT,            1'b1, 1'b0, SAT_LAT};
        vecs[4]  = '{64'hffff_0000_0000_0000, 64'h0,                   Q15_MIN_SAT,            1'b0, 1'b1, SAT_LAT};
        vecs[5]  = '{64'h0,                   64'h0,                   64'h0,                  1'b0, 1'b1, SAT_LAT};
        vecs[6]  = '{64'h0001_0000_0000_0000, 64'h0,                   Q15_MAX,                1'b0, 1'b1, SAT_LAT};
`ifdef Q15_DIV_ROUND_EN
        vecs[7]  = '{64'h0002_0000_0000_0000, 64'h0003_0000_0000_0000, 64'h0000_aaaa_aaaa_aaab, 1'b0, 1'b0, NORM_LAT};
`else
        vecs[7]  = '{64'h0002_0000_0000_0000, 64'h0003_0000_0000_0000, 64'h0000_aaaa_aaaa_aaaa, 1'b0, 1'b0, NORM_LAT};
`endif
        vecs[8]  = '{64'h8000_0000_0000_0000, Q15_ONE,                 Q15_MIN_SAT,            1'b1, 1'b0, SAT_LAT};
        vecs[9]  = '{Q15_MAX,                 Q15_ONE,                 Q15_MAX,                1'b0, 1'b0, NORM_LAT};
        vecs[10] = '{64'hffff_0000_0000_0000, 64'hffff_0000_0000_0000, Q15_ONE,                1'b0, 1'b0, NORM_LAT};
        vecs[11] = '{64'h0,                   64'hfffd_0000_0000_0000, 64'h0,                  1'b0, 1'b0, NORM_LAT};

        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].num, vecs[i].den, 1'b1, q, o, z, lat);
            check($sformatf("vec%0d_quot", i), q,           vecs[i].quot);
            check($sformatf("vec%0d_ovf", i),  64'(o),      64'(vecs[i].ovf));
            check($sformatf("vec%0d_dbz", i),  64'(z),      64'(vecs[i].dbz));
            check($sformatf("vec%0d_lat", i),  64'(lat),    64'(vecs[i].lat));
            check_release($sformatf("vec%0d", i));
        end

        // Backpressure: result held, new operands ignored while DONE
        run_div(64'h0001_0000_0000_0000, 64'h0002_0000_0000_0000, 1'b0, hold_q, o, z, lat);
        check("bp_first_quot", hold_q, 64'h0000_8000_0000_0000);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.num      = 64'h0003_0000_0000_0000;
            bus.den      = 64'h0001_0000_0000_0000;
            @(negedge clk);
            check($sformatf("bp%0d_quot", i),      bus.quot,           64'h0000_8000_0000_0000);
            check($sformatf("bp%0d_in_ready", i),  64'(bus.in_ready),  64'd0);
            check($sformatf("bp%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_release("bp");

        // Reset during DIV cycle 20 aborts the division
        @(negedge clk);
        bus.num      = 64'h0002_0000_0000_0000;
        bus.den      = 64'h0003_0000_0000_0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (21) @(negedge clk);
        check("mid_state_div", 64'(dbg_state), 64'(DIV));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_state",     64'(dbg_state),     64'(IDLE));
        check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_quot",      bus.quot,           64'd0);
        run_div(64'h0001_0000_0000_0000, 64'h0002_0000_0000_0000, 1'b1, q, o, z, lat);
        check("post_rst_quot", q,        64'h0000_8000_0000_0000);
        check("post_rst_lat",  64'(lat), 64'(NORM_LAT));
        check_release("post_rst");

        // Randomized operands against the reference model
        for (int i = 0; i < 40; i++) begin
            rn = {$urandom, $urandom} >> $urandom_range(0, 63);
            rd = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) rn = 64'd0 - rn;
            if ($urandom_range(0, 1) == 1) rd = 64'd0 - rd;
            if ($urandom_range(0, 15) == 0) rd = 64'd0;
            model(rn, rd, eq, eo, ez);
            exp_q.push_back({eq, eo, ez});
            run_div(rn, rd, 1'b1, q, o, z, lat);
            exp_item = exp_q.pop_front();
            check($sformatf("rnd%0d_quot", i), q,      exp_item[65:2]);
            check($sformatf("rnd%0d_ovf", i),  64'(o), 64'(exp_item[1]));
            check($sformatf("rnd%0d_dbz", i),  64'(z), 64'(exp_item[0]));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
